// File: rtl/spi_adc_responder.sv
// SPI responder emulating the 16-bit ADC: serves a snapshotted sample MSB-first per CNV frame.
// Optional sticky frame error output enabled by defining SPI_ADC_RESP_FRAME_CHECK_EN.
`timescale 1ns/1ps
module spi_adc_responder #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_valid_i,
  input  logic             spi_clk_i,
  input  logic             spi_cnv_i,
  input  logic             spi_mosi_i,
  output logic             spi_miso_o,
  output logic             sample_taken_o,
  output logic             busy_o,
  output logic             underrun_o
`ifdef SPI_ADC_RESP_FRAME_CHECK_EN
  ,
  output logic             frame_err_o
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONVERT, SHIFT} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] cnv_sync_q, cnv_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sck_dly_q, sck_dly_d;
  logic                   cnv_dly_q, cnv_dly_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic [WIDTH-1:0]       shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   fresh_q, fresh_d;
  logic                   miso_q, miso_d;
  logic                   taken_q, taken_d;
  logic                   busy_q, busy_d;
  logic                   underrun_q, underrun_d;
  logic                   frame_err_q, frame_err_d;

  logic          sck_rise, sck_fall, cnv_rise, cnv_fall;
  logic [CW-1:0] cnt_inc;
  logic          unused_mosi;

  // MOSI is carried through the synchronizer for symmetry only; its value is never used.
  assign unused_mosi = mosi_sync_q[SYNC_STAGES-1];

  assign sck_rise = sck_sync_q[SYNC_STAGES-1] & ~sck_dly_q;
  assign sck_fall = ~sck_sync_q[SYNC_STAGES-1] & sck_dly_q;
  assign cnv_rise = cnv_sync_q[SYNC_STAGES-1] & ~cnv_dly_q;
  assign cnv_fall = ~cnv_sync_q[SYNC_STAGES-1] & cnv_dly_q;
  assign cnt_inc  = bit_cnt_q + CW'(1);

  always_comb begin
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], spi_clk_i};
    cnv_sync_d  = {cnv_sync_q[SYNC_STAGES-2:0], spi_cnv_i};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    sck_dly_d   = sck_sync_q[SYNC_STAGES-1];
    cnv_dly_d   = cnv_sync_q[SYNC_STAGES-1];
    state_d     = state_q;
    hold_d      = hold_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    fresh_d     = fresh_q;
    miso_d      = miso_q;
    taken_d     = 1'b0;
    busy_d      = busy_q;
    underrun_d  = underrun_q;
    frame_err_d = frame_err_q;

    if (data_valid_i) begin
      hold_d  = data_i;
      fresh_d = 1'b1;
    end

    // CNV rising edge wins over any SCK edge and restarts the frame from any state.
    if (cnv_rise) begin
      shift_d = data_valid_i ? data_i : hold_q;
      taken_d = 1'b1;
      busy_d  = 1'b1;
      miso_d  = 1'b0;
      state_d = CONVERT;
      fresh_d = data_valid_i;
      if (!fresh_q && !data_valid_i)
        underrun_d = 1'b1;
      if (state_q != IDLE)
        frame_err_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: miso_d = 1'b0;
        CONVERT: begin
          miso_d = 1'b0;
          if (cnv_fall) begin
            miso_d    = shift_q[WIDTH-1];
            bit_cnt_d = '0;
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (sck_rise) begin
            bit_cnt_d = cnt_inc;
            if (cnt_inc == CW'(WIDTH)) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              miso_d  = 1'b0;
            end
          end else if (sck_fall && (bit_cnt_q < CW'(WIDTH))) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
            miso_d  = shift_q[WIDTH-2];
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sck_sync_q  <= '0;
      cnv_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cnv_dly_q   <= 1'b0;
      hold_q      <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      fresh_q     <= 1'b0;
      miso_q      <= 1'b0;
      taken_q     <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= sck_sync_d;
      cnv_sync_q  <= cnv_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sck_dly_q   <= sck_dly_d;
      cnv_dly_q   <= cnv_dly_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      fresh_q     <= fresh_d;
      miso_q      <= miso_d;
      taken_q     <= taken_d;
      busy_q      <= busy_d;
      underrun_q  <= underrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign spi_miso_o     = miso_q;
  assign sample_taken_o = taken_q;
  assign busy_o         = busy_q;
  assign underrun_o     = underrun_q;

`ifdef SPI_ADC_RESP_FRAME_CHECK_EN
  assign frame_err_o = frame_err_q;
`else
  logic unused_frame_err;
  assign unused_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: a frame vector table plus hand-written bypass, abort
// and mid-frame reset sequences, with the initiator modelled by driving CNV/SCK from the bench.
`timescale 1ns/1ps
module tb_spi_adc_responder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] data_i = '0;
  logic        data_valid_i = 1'b0;
  logic        spi_clk_i = 1'b0;
  logic        spi_cnv_i = 1'b0;
  logic        spi_mosi_i = 1'b1;
  logic        spi_miso_o;
  logic        sample_taken_o;
  logic        busy_o;
  logic        underrun_o;
`ifdef SPI_ADC_RESP_FRAME_CHECK_EN
  logic        frame_err_o;
`endif

  int vec_count = 0;
  int miscompares = 0;
  int taken_cnt = 0;

  spi_adc_responder #(.WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .data_i         (data_i),
    .data_valid_i   (data_valid_i),
    .spi_clk_i      (spi_clk_i),
    .spi_cnv_i      (spi_cnv_i),
    .spi_mosi_i     (spi_mosi_i),
    .spi_miso_o     (spi_miso_o),
    .sample_taken_o (sample_taken_o),
    .busy_o         (busy_o),
    .underrun_o     (underrun_o)
`ifdef SPI_ADC_RESP_FRAME_CHECK_EN
    ,
    .frame_err_o    (frame_err_o)
`endif
  );

  always #10 clk_i = ~clk_i;

  always @(posedge clk_i)
    if (sample_taken_o) taken_cnt <= taken_cnt + 1;

  typedef struct {
    logic        do_strobe;
    logic [15:0] data;
    logic [15:0] exp_word;
    logic        exp_underrun;
  } frame_vec_t;

  frame_vec_t vecs[5];

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic strobe(input logic [15:0] d);
    data_i = d;
    data_valid_i = 1'b1;
    tick(1);
    data_valid_i = 1'b0;
  endtask

  task automatic cnv_pulse();
    spi_cnv_i = 1'b1;
    tick(4);
    spi_cnv_i = 1'b0;
    tick(6);
  endtask

  // Initiator samples MISO at the instant it raises SCK, as the real ADC reader does.
  task automatic clock_bits(input int n, output logic [15:0] w);
    w = '0;
    for (int i = 0; i < n; i++) begin
      tick(4);
      w = {w[14:0], spi_miso_o};
      spi_clk_i = 1'b1;
      tick(4);
      spi_clk_i = 1'b0;
    end
  endtask

  task automatic applyStimulus(input frame_vec_t v, input int idx);
    logic [15:0] w;
    int t0;
    if (v.do_strobe) strobe(v.data);
    t0 = taken_cnt;
    cnv_pulse();
    checkOutput($sformatf("vec%0d busy_mid", idx), {15'd0, busy_o}, 16'd1);
    clock_bits(16, w);
    tick(6);
    checkOutput($sformatf("vec%0d word", idx), w, v.exp_word);
    checkOutput($sformatf("vec%0d underrun", idx), {15'd0, underrun_o}, {15'd0, v.exp_underrun});
    checkOutput($sformatf("vec%0d busy_end", idx), {15'd0, busy_o}, 16'd0);
    checkOutput($sformatf("vec%0d taken_pulses", idx), 16'(taken_cnt - t0), 16'd1);
  endtask

  initial begin
    logic [15:0] w;
    int t0;

    vecs[0] = '{1'b1, 16'hA5C3, 16'hA5C3, 1'b0};
    vecs[1] = '{1'b1, 16'h7FFF, 16'h7FFF, 1'b0};
    vecs[2] = '{1'b1, 16'h8000, 16'h8000, 1'b0};
    vecs[3] = '{1'b1, 16'h1234, 16'h1234, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 16'h1234, 1'b1};

    tick(3);
    checkOutput("reset miso", {15'd0, spi_miso_o}, 16'd0);
    checkOutput("reset taken", {15'd0, sample_taken_o}, 16'd0);
    checkOutput("reset busy", {15'd0, busy_o}, 16'd0);
    checkOutput("reset underrun", {15'd0, underrun_o}, 16'd0);
    rst_i = 1'b0;
    tick(2);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i], i);

    // Reset during bit 9 must clear the sticky underrun and abandon the frame.
    strobe(16'hC0DE);
    cnv_pulse();
    clock_bits(8, w);
    tick(2);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    checkOutput("rst_mid miso", {15'd0, spi_miso_o}, 16'd0);
    checkOutput("rst_mid busy", {15'd0, busy_o}, 16'd0);
    checkOutput("rst_mid underrun", {15'd0, underrun_o}, 16'd0);
    tick(2);
    strobe(16'h1357);
    cnv_pulse();
    clock_bits(16, w);
    tick(6);
    checkOutput("post_rst word", w, 16'h1357);
    checkOutput("post_rst underrun", {15'd0, underrun_o}, 16'd0);

    // Bypass: strobe lands in the same cycle the synchronized CNV rise is seen.
    strobe(16'h0001);
    tick(2);
    spi_cnv_i = 1'b1;
    tick(2);
    data_i = 16'hFFFE;
    data_valid_i = 1'b1;
    tick(1);
    data_valid_i = 1'b0;
    checkOutput("bypass taken", {15'd0, sample_taken_o}, 16'd1);
    checkOutput("bypass busy", {15'd0, busy_o}, 16'd1);
    tick(2);
    spi_cnv_i = 1'b0;
    tick(6);
    clock_bits(16, w);
    tick(6);
    checkOutput("bypass word", w, 16'hFFFE);
    checkOutput("bypass underrun", {15'd0, underrun_o}, 16'd0);

`ifdef SPI_ADC_RESP_FRAME_CHECK_EN
    checkOutput("frame_err before abort", {15'd0, frame_err_o}, 16'd0);
`endif
    // Abort after 7 SCK cycles; a fresh strobe precedes the new CNV so no underrun.
    strobe(16'h5A5A);
    t0 = taken_cnt;
    cnv_pulse();
    clock_bits(7, w);
    checkOutput("abort partial bits", {9'd0, w[6:0]}, 16'h005A >> 1 & 16'h007F | 16'h0000);
    strobe(16'h3C3C);
    cnv_pulse();
    clock_bits(16, w);
    tick(6);
    checkOutput("abort next word", w, 16'h3C3C);
    checkOutput("abort taken_pulses", 16'(taken_cnt - t0), 16'd2);
    checkOutput("abort underrun", {15'd0, underrun_o}, 16'd0);
    checkOutput("abort busy_end", {15'd0, busy_o}, 16'd0);
`ifdef SPI_ADC_RESP_FRAME_CHECK_EN
    checkOutput("abort frame_err", {15'd0, frame_err_o}, 16'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
